// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM (MAR load / read-enable / write-load
// interface with a registered read output) between two requesters using a
// simple req/done handshake. One transaction is in flight at a time.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req[1:0]         per-port request, held until that port's done pulse
//   we[1:0]          per-port write enable (1 = write), sampled at grant
//   addr0/addr1      per-port address, sampled at grant
//   wdata0/wdata1    per-port write data, sampled at grant
//   done[1:0]        one-cycle completion pulse for the granted port
//   rdata0/rdata1    per-port read data, held until that port's next read
//   busy             high whenever the FSM is not idle
//   grant[1:0]       one-hot owner of the current transaction, 0 when idle
//   ram_mar_load     RAM MAR load strobe
//   ram_en           RAM read enable (output register load)
//   ram_load         RAM write strobe
//   ram_wbus         value driven onto the RAM bus input
//   ram_rdata        RAM registered read output
module ram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int FIX_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [1:0]    grant,
  output logic          ram_mar_load,
  output logic          ram_en,
  output logic          ram_load,
  output logic [DW-1:0] ram_wbus,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          last_grant_r;
  logic [1:0]    grant_r;
  logic [AW-1:0] addr_r;
  logic          we_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic          win_s;
  logic [DW-1:0] addr_ext_s;

  // Arbitration: a lone requester wins; a tie goes to port 0 (fixed) or
  // to the port that did not win last time (round-robin).
  always_comb begin
    win_s = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = (FIX_PRIO != 0) ? 1'b0 : ~last_grant_r;
      default: win_s = 1'b0;
    endcase
  end

  // Zero-extend the latched address to the RAM bus width.
  always_comb begin
    addr_ext_s         = '0;
    addr_ext_s[AW-1:0] = addr_r;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) state_s = ADDR;
        else              state_s = IDLE;
      end
      ADDR:    state_s = ACCESS;
      ACCESS: begin
        if (we_r) state_s = DONE;      // writes need no capture cycle
        else      state_s = CAPTURE;
      end
      CAPTURE: state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // RAM strobes and bus decoded from state; only one strobe is high per state.
  always_comb begin
    ram_mar_load = 1'b0;
    ram_en       = 1'b0;
    ram_load     = 1'b0;
    ram_wbus     = '0;
    done         = 2'b00;
    case (state_r)
      ADDR: begin
        ram_mar_load = 1'b1;
        ram_wbus     = addr_ext_s;
      end
      ACCESS: begin
        if (we_r) begin
          ram_load = 1'b1;
          ram_wbus = wdata_r;
        end else begin
          ram_en   = 1'b1;
        end
      end
      DONE:    done = grant_r;
      default: done = 2'b00;
    endcase
  end

  // Status and data outputs driven straight from registers.
  always_comb begin
    busy   = (state_r != IDLE);
    grant  = grant_r;
    rdata0 = rdata0_r;
    rdata1 = rdata1_r;
  end

  // State register, grant/latch capture and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;            // so port 0 wins the first tie
      grant_r      <= 2'b00;
      addr_r       <= '0;
      we_r         <= 1'b0;
      wdata_r      <= '0;
      rdata0_r     <= '0;
      rdata1_r     <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            grant_r      <= win_s ? 2'b10 : 2'b01;
            last_grant_r <= win_s;
            addr_r       <= win_s ? addr1 : addr0;
            we_r         <= we[win_s];
            wdata_r      <= win_s ? wdata1 : wdata0;
          end else begin
            grant_r      <= 2'b00;
          end
        end
        CAPTURE: begin
          // RAM output was registered on the ACCESS edge
          if (grant_r[0])      rdata0_r <= ram_rdata;
          else if (grant_r[1]) rdata1_r <= ram_rdata;
          else                 rdata0_r <= rdata0_r;
        end
        DONE:    grant_r <= 2'b00;
        default: grant_r <= grant_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (round-robin and fixed priority)
// share one stimulus stream, each attached to its own behavioural RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic [1:0]  done, grant;
  logic [15:0] rdata0, rdata1, wbus, rout;
  logic        busy, mar_load, en, load;
  logic [7:0]  mar;
  logic [15:0] mem [256];

  logic [1:0]  fdone, fgrant;
  logic [15:0] frdata0, frdata1, fwbus, frout;
  logic        fbusy, fmar_load, fen, fload;
  logic [7:0]  fmar;
  logic [15:0] fmem [256];

  typedef struct packed {
    logic [1:0]  d;
    logic [15:0] r0;
    logic [15:0] r1;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [1:0]  prev_done;
  logic        tie_phase;
  int          fix_cnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(12), .DW(16), .FIX_PRIO(0)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done(done), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .grant(grant), .ram_mar_load(mar_load), .ram_en(en),
    .ram_load(load), .ram_wbus(wbus), .ram_rdata(rout)
  );

  ram_arbiter #(.AW(12), .DW(16), .FIX_PRIO(1)) dut_fix (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done(fdone), .rdata0(frdata0), .rdata1(frdata1),
    .busy(fbusy), .grant(fgrant), .ram_mar_load(fmar_load), .ram_en(fen),
    .ram_load(fload), .ram_wbus(fwbus), .ram_rdata(frout)
  );

  // Behavioural RAMs: MAR register, write on load, registered read on en.
  always @(posedge clk) begin
    if (preload) begin
      mem[8'h0D]  <= 16'h0001;
      mem[8'h21]  <= 16'h1234;
      fmem[8'h0D] <= 16'h0001;
      fmem[8'h21] <= 16'h1234;
    end else begin
      if (mar_load)  mar   <= wbus[7:0];
      if (load)      mem[mar] <= wbus;
      if (en)        rout  <= mem[mar];
      if (fmar_load) fmar  <= fwbus[7:0];
      if (fload)     fmem[fmar] <= fwbus;
      if (fen)       frout <= fmem[fmar];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done != 2'b00) begin
      chk("done_gap", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_port", 32'(done), 32'(mon_e.d));
        chk("rdata0", 32'(rdata0), 32'(mon_e.r0));
        chk("rdata1", 32'(rdata1), 32'(mon_e.r1));
      end
    end
    if (tie_phase && fdone != 2'b00) begin
      chk("fix_grant", 32'(fdone), 32'd1);
      fix_cnt++;
    end
    prev_done <= done;
  end

  // One single-port transaction with cycle-accurate strobe checks.
  task automatic xact(input int p, input logic w, input logic [11:0] a,
                      input logic [15:0] d, input logic [15:0] e0, input logic [15:0] e1);
    int lat;
    logic [1:0] pm;
    pm = (p == 1) ? 2'b10 : 2'b01;
    req[p] = 1'b1;
    we[p]  = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    sb.push_back(exp_t'({pm, e0, e1}));
    @(negedge clk);                              // ADDR cycle
    chk("addr_ctrl", 32'({mar_load, en, load}), 32'd4);
    chk("addr_wbus", 32'(wbus), 32'(a));
    chk("addr_grant", 32'(grant), 32'(pm));
    chk("addr_busy", 32'(busy), 32'd1);
    addr0 = 12'hFFF; addr1 = 12'hFFF;            // post-grant changes must be ignored
    wdata0 = 16'h0BAD; wdata1 = 16'h0BAD;
    we[p] = ~w;
    @(negedge clk);                              // ACCESS cycle
    if (w) begin
      chk("wr_ctrl", 32'({mar_load, en, load}), 32'd1);
      chk("wr_wbus", 32'(wbus), 32'(d));
    end else begin
      chk("rd_ctrl", 32'({mar_load, en, load}), 32'd2);
      chk("rd_wbus", 32'(wbus), 32'd0);
    end
    lat = 2;
    while (done == 2'b00 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), w ? 32'd3 : 32'd4);
    req[p] = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; preload = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tie_phase = 1'b0; fix_cnt = 0; prev_done = 2'b00;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({done, grant, mar_load, en, load}), 32'd0);
    chk("rst_wbus", 32'(wbus), 32'd0);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xact(0, 1'b0, 12'h00D, 16'h0000, 16'h0001, 16'h0000);
    xact(1, 1'b1, 12'h020, 16'hBEEF, 16'h0001, 16'h0000);
    xact(0, 1'b0, 12'h020, 16'h0000, 16'hBEEF, 16'h0000);
    xact(1, 1'b0, 12'h320, 16'h0000, 16'hBEEF, 16'hBEEF);

    // Both ports request continuous reads
    tie_phase = 1'b1;
    we = 2'b00; addr0 = 12'h00D; addr1 = 12'h021; req = 2'b11;
    sb.push_back(exp_t'({2'b01, 16'h0001, 16'hBEEF}));
    sb.push_back(exp_t'({2'b10, 16'h0001, 16'h1234}));
    sb.push_back(exp_t'({2'b01, 16'h0001, 16'h1234}));
    sb.push_back(exp_t'({2'b10, 16'h0001, 16'h1234}));
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (done == 2'b00 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      chk("tie_done_seen", 32'(done != 2'b00), 32'd1);
      if (k == 3) req = 2'b00;
      @(negedge clk);
      chk("tie_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("tie_rearm", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
    end
    tie_phase = 1'b0;
    chk("fix_count", 32'(fix_cnt), 32'd4);

    // Port 0 drops req during ADDR: still completes, no second grant
    req = 2'b01; we = 2'b00; addr0 = 12'h00D;
    sb.push_back(exp_t'({2'b01, 16'h0001, 16'h1234}));
    @(negedge clk);
    req = 2'b00;
    chk("drop_grant", 32'(grant), 32'd1);
    cnt = 0;
    while (done == 2'b00 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("drop_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("drop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("drop_no_regrant", 32'({busy, grant}), 32'd0);

    // Reset during ACCESS of a write aborts with no done pulse
    req = 2'b10; we = 2'b10; addr1 = 12'h030; wdata1 = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    chk("abort_access", 32'({mar_load, en, load}), 32'd1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    chk("abort_outs", 32'({busy, done, grant, mar_load, en, load}), 32'd0);
    chk("abort_wbus", 32'(wbus), 32'd0);
    chk("abort_rdata", {rdata0, rdata1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    xact(0, 1'b0, 12'h00D, 16'h0000, 16'h0001, 16'h0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 256x16 RAM between two requesters: port 0 is the CPU controller, port 1 is a program loader or debug port.
- Converts each requester's simple req/done transaction into the RAM's native sequence: MAR load, then read-enable or write-load, then capture.
- Sits between the requesters and the ram block's mar_load / ram_en / ram_load / bus / out interface.
- Provides round-robin or fixed-priority arbitration, one transaction in flight at a time.

Parameters:
- AW, 12, address width of requester ports; RAM uses the low 8 bits, the full AW bits are driven onto the MAR.
- DW, 16, data word width.
- FIX_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a tie.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-port request; must be held until that port's done pulse.
- we  in  2  per-port write enable (1 = write, 0 = read); sampled at grant.
- addr0, addr1  in  AW  per-port address; sampled at grant.
- wdata0, wdata1  in  DW  per-port write data; sampled at grant.
- done  out  2  one-cycle completion pulse for the granted port.
- rdata0, rdata1  out  DW  per-port read data; valid from that port's done pulse until its next read completes.
- busy  out  1  high in every state except IDLE.
- grant  out  2  one-hot owner of the current transaction; 0 in IDLE.
- ram_mar_load  out  1  to ram mar_load.
- ram_en  out  1  to ram ram_en.
- ram_load  out  1  to ram ram_load.
- ram_wbus  out  DW  value driven onto the RAM bus input.
- ram_rdata  in  DW  from ram out.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - Latched addr, we and wdata cleared.
  - rdata0=rdata1=0; done=0, grant=0.
  - All ram_* controls 0; ram_wbus=0.
  - Reset mid-transaction aborts it: no done pulse. A partially sequenced write is not guaranteed to land.
- FSM states: IDLE, ADDR, ACCESS, CAPTURE, DONE.
- IDLE:
  - If req!=0, pick a winner: single requester wins.
  - On a tie: FIX_PRIO=1 gives port 0; FIX_PRIO=0 gives the port other than last_grant.
  - Latch the winner's addr, we and wdata; set grant; go to ADDR.
  - last_grant updates at grant time.
- ADDR: ram_mar_load=1, ram_wbus=zero-extended latched addr; go to ACCESS.
- ACCESS:
  - Read: ram_en=1, ram_wbus=0; go to CAPTURE.
  - Write: ram_load=1, ram_wbus=latched wdata; go to DONE.
- CAPTURE: ram_rdata is valid (the RAM registers out on the ACCESS edge). Latch it into rdata of the granted port; go to DONE.
- DONE: done[granted]=1 for exactly this cycle; grant stays held; go to IDLE.
- Latency from the IDLE edge that samples req to the done cycle: read 4 cycles, write 3 cycles.
- Throughput: one read per 5 cycles, one write per 4 cycles (IDLE cycle included).
- ram_mar_load, ram_en and ram_load are decoded combinationally from state plus latched we. They are mutually exclusive and never glitch to two-high.
- Handshake rules:
  - A requester that still holds req in the IDLE cycle after its done starts a new transaction.
  - Dropping req mid-transaction does not abort it; done is still pulsed.
  - addr, we and wdata changes after grant are ignored.
- rdata of the non-granted port never changes. A write does not alter rdata of either port.
- Simultaneous new req on the other port during a transaction is held pending and served at the next IDLE, subject to the arbitration rule.

Test Plan:
- Reset, then port 0 reads addr 0x00D, RAM holding 0x0001 there:
  - mar_load at cycle 1 with ram_wbus=0x000D; ram_en at cycle 2.
  - done=2'b01 at cycle 4; rdata0=0x0001; rdata1 unchanged (0).
- Port 1 writes 0xBEEF to addr 0x020:
  - ram_load at cycle 2 with ram_wbus=0xBEEF; done=2'b10 at cycle 3.
  - A following port 0 read of 0x020 returns 0xBEEF.
- Both ports request continuous reads with FIX_PRIO=0:
  - Grants alternate 01,10,01,10 starting with port 0.
  - With FIX_PRIO=1, port 0 is granted every time.
- Port 0 deasserts req in the ADDR cycle: transaction completes, done[0] pulses, the FSM returns to IDLE, and no second grant follows.
- rst asserted during ACCESS of a write: next cycle state=IDLE, all outputs 0, and no done pulse.
- Port 0 holds req through done: exactly one IDLE cycle with busy=0 occurs between back-to-back transactions, and done is never high for two consecutive cycles.
